prach_nco: RTL
==============

# prach_nco

Numerically controlled oscillator producing the complex rotation phasor e^{j·2π·phase/2^PHASE_WIDTH} used to frequency-shift the PRACH long sequence. It sits directly upstream of the complex multiplier: its cos/sin outputs drive the multiplier's `br`/`bi` inputs. Output amplitude is 2^14, matching the multiplier's default SHIFT of 14. It is a phase accumulator, a quarter-wave sine table and a 3-stage pipeline with a valid strobe.

## Interface
- PHASE_WIDTH, 24: phase accumulator and frequency control word width; one full turn is 2^PHASE_WIDTH.
- LUT_ADDR, 10: quarter-wave table index width; the table holds N+1 entries, N = 2^LUT_ADDR.
- OUT_WIDTH, 16: signed output width; must be at least 16.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fcw  in  PHASE_WIDTH  frequency control word (unsigned); sampled when `in_valid`=1.
- phase_ofs  in  PHASE_WIDTH  static phase offset; sampled when `in_valid`=1.
- sync  in  1  accumulator restart strobe.
- in_valid  in  1  request one output sample and advance the phase.
- out_valid  out  1  `cos_out`/`sin_out` hold a new sample.
- cos_out  out  OUT_WIDTH  signed real part.
- sin_out  out  OUT_WIDTH  signed imaginary part.

## Operation
- Accumulator `acc` (PHASE_WIDTH bits, unsigned) is modulo 2^PHASE_WIDTH; wrap-around is silent.
- Sample phase p = (sync ? 0 : acc) + phase_ofs, taken mod 2^PHASE_WIDTH.
- Accumulator update:
  - `in_valid`=1: acc <= (sync ? 0 : acc) + fcw.
  - `in_valid`=0 and `sync`=1: acc <= 0.
  - Otherwise acc holds.
- Quadrant Q = p[PHASE_WIDTH-1:PHASE_WIDTH-2].
- Index k = p[PHASE_WIDTH-3 -: LUT_ADDR].
- Lower phase bits are truncated; there is no rounding or dither.
- Table: q[i] = round(16384·sin(π/2·i/N)), i = 0..N, so q[0]=0 and q[N]=16384.
  - Built at elaboration as a constant ROM.
  - Implemented as a registered read of two ports, q[k] and q[N-k].
- Quadrant mapping (cos, sin):
  - Q=0: (q[N-k], q[k])
  - Q=1: (-q[k], q[N-k])
  - Q=2: (-q[N-k], -q[k])
  - Q=3: (q[k], -q[N-k])
- Results are sign-extended to OUT_WIDTH. The magnitude never exceeds 16384, so the outputs never overflow.
- Pipeline:
  - S1 registers p, Q and k.
  - S2 registers the table reads and Q.
  - S3 registers the negate/swap result.
- The valid bit travels with the data through S1–S3.
- No backpressure: the pipeline never stalls.
- A data stage loads only when its valid bit is 1; otherwise it holds its previous value.

## Timing
- Latency: `in_valid` high at edge n gives `out_valid` high after edge n+3, with the corresponding sample on the outputs.
- Throughput: one sample per cycle; back-to-back `in_valid` yields back-to-back `out_valid`.
- Reset values, applied asynchronously on `rst_n`=0:
  - acc = 0; all pipeline valid bits = 0.
  - out_valid = 0, cos_out = 0, sin_out = 0.
- Reset mid-stream: in-flight samples are discarded. The first `in_valid` after release uses phase phase_ofs.
- `sync` and `in_valid` in the same cycle: that sample uses phase phase_ofs, and acc becomes fcw.
- Changing `fcw` takes effect on the next `in_valid`; samples already issued are unaffected.
- `out_valid` is exactly `in_valid` delayed by 3 cycles. It never asserts without a matching request.

## Test plan
- **Reset:** hold rst_n=0, then release → out_valid=0, cos_out=0, sin_out=0; the first sample with fcw=0 and phase_ofs=0 is (16384, 0) at 3-cycle latency.
- **Quarter-turn step:** fcw=2^22, phase_ofs=0, with in_valid held for 5 cycles → outputs (16384,0), (0,16384), (-16384,0), (0,-16384), (16384,0). Checks wrap-around.
- **Offset and sync:** phase_ofs=2^23, fcw=2^20, `sync` pulsed with the 4th in_valid → samples 1–3 track phases 2^23 + {0, 1, 2}·2^20; sample 4 restarts at phase 2^23, giving (-16384, 0).
- **Gapped input:** in_valid pattern 1,0,1,1,0 → out_valid pattern 0,0,0,1,0,1,1,0; acc advances only 3 times; outputs hold during gaps.
- **Sweep:** fcw=1237 for 20000 samples, compared against a double-precision model using the same truncation → exact match to the quantised table; |cos|,|sin| ≤ 16384; cos²+sin² within ±0.1% of 16384².
- **Async reset mid-stream:** assert rst_n=0 for 1 cycle while 3 samples are in flight → out_valid stays 0 for those samples; acc=0 after release.

Source files
------------

// File: rtl/prach_nco.sv
// PRACH rotation NCO: phase accumulator, quarter-wave sine ROM and a 3-stage pipeline.
// Emits cos/sin of 2*pi*phase/2^PHASE_WIDTH at amplitude 2^14 with a valid strobe.
module prach_nco #(
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_ADDR    = 10,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PHASE_WIDTH-1:0]      fcw,
  input  logic [PHASE_WIDTH-1:0]      phase_ofs,
  input  logic                        sync,
  input  logic                        in_valid,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] cos_out,
  output logic signed [OUT_WIDTH-1:0] sin_out
);

  localparam int N  = 32'sd1 << LUT_ADDR;
  localparam int QW = 15;
  localparam int FB = 60;

  typedef logic signed [127:0] fx_t;

  // atan(1/n) in FB-bit fixed point; used to build pi by Machin's formula
  function automatic fx_t atan_inv(input int n);
    fx_t pw;
    fx_t sum;
    fx_t term;
    pw  = (128'sd1 <<< FB) / fx_t'(n);
    sum = 128'sd0;
    for (int j = 0; j < 40; j++) begin
      term = pw / fx_t'(2 * j + 1);
      if (j[0]) begin
        sum = sum - term;
      end else begin
        sum = sum + term;
      end
      pw = pw / fx_t'(n * n);
    end
    return sum;
  endfunction

  function automatic logic [QW-1:0] qsin(input int i);
    fx_t hpi;
    fx_t x;
    fx_t x2;
    fx_t term;
    fx_t sum;
    hpi  = 128'sd8 * atan_inv(5) - 128'sd2 * atan_inv(239);
    x    = (hpi * fx_t'(i)) / fx_t'(N);
    x2   = (x * x) >>> FB;
    term = x;
    sum  = x;
    for (int j = 1; j < 20; j++) begin
      term = -((term * x2) >>> FB) / fx_t'((2 * j) * (2 * j + 1));
      sum  = sum + term;
    end
    return QW'((sum * 128'sd16384 + (128'sd1 <<< (FB - 1))) >>> FB);
  endfunction

  logic [QW-1:0] rom [0:N];

  for (genvar gi = 0; gi <= N; gi++) begin : g_rom
    localparam logic [QW-1:0] QV = qsin(gi);
    assign rom[gi] = QV;
  end

  logic [PHASE_WIDTH-1:0]      acc_q, acc_d;
  logic                        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [1:0]                  quad1_q, quad1_d, quad2_q, quad2_d;
  logic [LUT_ADDR-1:0]         k1_q, k1_d;
  logic [QW-1:0]               qa_q, qa_d, qb_q, qb_d;
  logic signed [OUT_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;

  logic [PHASE_WIDTH-1:0]           base;
  logic [PHASE_WIDTH-1:0]           phase;
  logic [PHASE_WIDTH-LUT_ADDR-3:0]  unused_lsbs;
  logic [LUT_ADDR:0]                idx_a, idx_b;
  logic signed [OUT_WIDTH-1:0]      pa, pb;

  // Next-state logic for accumulator and all three pipeline stages
  always_comb begin
    base        = sync ? '0 : acc_q;
    phase       = base + phase_ofs;
    unused_lsbs = phase[PHASE_WIDTH-LUT_ADDR-3:0];

    if (in_valid) begin
      acc_d = base + fcw;
    end else if (sync) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q;
    end

    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;

    if (in_valid) begin
      quad1_d = phase[PHASE_WIDTH-1 -: 2];
      k1_d    = phase[PHASE_WIDTH-3 -: LUT_ADDR];
    end else begin
      quad1_d = quad1_q;
      k1_d    = k1_q;
    end

    // qa holds q[k], qb holds q[N-k]
    idx_a = {1'b0, k1_q};
    idx_b = (LUT_ADDR + 1)'(N) - idx_a;
    if (v1_q) begin
      qa_d    = rom[idx_a];
      qb_d    = rom[idx_b];
      quad2_d = quad1_q;
    end else begin
      qa_d    = qa_q;
      qb_d    = qb_q;
      quad2_d = quad2_q;
    end

    pa    = OUT_WIDTH'({1'b0, qa_q});
    pb    = OUT_WIDTH'({1'b0, qb_q});
    cos_d = cos_q;
    sin_d = sin_q;
    if (v2_q) begin
      case (quad2_q)
        2'd0: begin cos_d = pb;  sin_d = pa;  end
        2'd1: begin cos_d = -pa; sin_d = pb;  end
        2'd2: begin cos_d = -pb; sin_d = -pa; end
        2'd3: begin cos_d = pa;  sin_d = -pb; end
        default: begin cos_d = cos_q; sin_d = sin_q; end
      endcase
    end else begin
      cos_d = cos_q;
      sin_d = sin_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      quad1_q <= 2'd0;
      k1_q    <= '0;
      qa_q    <= '0;
      qb_q    <= '0;
      quad2_q <= 2'd0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      quad1_q <= quad1_d;
      k1_q    <= k1_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      quad2_q <= quad2_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign out_valid = v3_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule
